// File: rtl/im_loader_if.sv
// Program-load bundle between a byte-stream host and the instruction-memory loader.
// The loader sits on the slave side; the host/bench drives the master side.
interface im_loader_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              start;
  logic [ADDR_W:0]   load_len;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, load_len, byte_in, byte_valid,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, load_len, byte_in, byte_valid,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/im_loader.sv
// Streams big-endian bytes into 32-bit instruction-memory writes while holding the CPU in reset.
// Optional trailing XOR checksum byte is compiled in with IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input logic        i_clk,
  input logic        i_rst,
  im_loader_if.slave io_bus
);

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StCheck, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone} state_e;
`endif

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  state_e            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;
  logic              r_byte_ready;
  logic              r_im_we;
  logic [ADDR_W-1:0] r_im_addr;
  logic [31:0]       r_im_wdata;
  logic              r_cpu_rst;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              w_accept;
  logic [ADDR_W:0]   w_word_next;

  assign w_accept    = io_bus.byte_valid & r_byte_ready;
  assign w_word_next = r_word_cnt + (ADDR_W+1)'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_byte_ready <= 1'b0;
      r_im_we      <= 1'b0;
      r_im_addr    <= '0;
      r_im_wdata   <= '0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      r_xor        <= '0;
`endif
    end else begin
      r_im_we <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_len      <= io_bus.load_len;
            r_err      <= 1'b0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_cpu_rst  <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
            if (io_bus.load_len > MaxLen) begin
              // Oversize request is rejected without leaving IDLE.
              r_err <= 1'b1;
            end else if (io_bus.load_len == '0) begin
              r_busy <= 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
              r_state      <= StCheck;
              r_byte_ready <= 1'b1;
`else
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
`endif
            end else begin
              r_state      <= StLoad;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end

        StLoad: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], io_bus.byte_in};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ io_bus.byte_in;
`endif
            if (r_byte_cnt == 2'd3) begin
              r_state      <= StWrite;
              r_byte_ready <= 1'b0;
              r_im_we      <= 1'b1;
              r_im_addr    <= r_word_cnt[ADDR_W-1:0];
              r_im_wdata   <= {r_shift, io_bus.byte_in};
            end
          end
        end

        StWrite: begin
          r_word_cnt <= w_word_next;
          if (w_word_next == r_len) begin
`ifdef IM_LOADER_CHECKSUM_EN
            r_state      <= StCheck;
            r_byte_ready <= 1'b1;
`else
            r_state   <= StDone;
            r_done    <= 1'b1;
            r_cpu_rst <= 1'b0;
`endif
          end else begin
            r_state      <= StLoad;
            r_byte_ready <= 1'b1;
          end
        end

`ifdef IM_LOADER_CHECKSUM_EN
        StCheck: begin
          if (w_accept) begin
            r_byte_ready <= 1'b0;
            if (io_bus.byte_in == r_xor) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state <= StIdle;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
`endif

        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= StIdle;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.byte_ready = r_byte_ready;
  assign io_bus.im_we      = r_im_we;
  assign io_bus.im_addr    = r_im_addr;
  assign io_bus.im_wdata   = r_im_wdata;
  assign io_bus.cpu_rst    = r_cpu_rst;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.err        = r_err;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed vector table, multi-cycle corner cases and
// randomized loads checked against a word-level reference model.
module tb_im_loader;
  localparam int unsigned ADDR_W  = 10;
  localparam int          MAX_LEN = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  im_loader_if #(.ADDR_W(ADDR_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    string       name;
    int          len;
    int          gap_at;
    int          gap_len;
    int          exp_nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_err;
    logic        exp_cpu_rst;
    int          exp_done;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  wq[$];
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  int   start_cyc = 0;
  logic [7:0] prog[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe registered outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.im_we) wq.push_back('{addr: bus.im_addr, data: bus.im_wdata});
    if (bus.done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    bus.load_len = (ADDR_W+1)'(len);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    start_cyc    = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 50) begin
      tick();
      t++;
    end
    ok = bus.byte_ready;
    if (ok) tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 200) begin
      tick();
      t++;
    end
    check("idle_reached", {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] bq[$]);
    logic [7:0] x = 8'h00;
    foreach (bq[i]) x ^= bq[i];
    return x;
  endfunction

  task automatic run_load(input int len, input logic [7:0] bq[$], input int gap_at,
                          input int gap_len);
    bit ok;
    do_start(len);
    foreach (bq[i]) begin
      if (i == gap_at) tick(gap_len);
      send_byte(bq[i], ok);
      check("byte_accept", {63'd0, ok}, 64'd1);
    end
`ifdef IM_LOADER_CHECKSUM_EN
    if (len <= MAX_LEN) begin
      send_byte(xor_of(bq), ok);
      check("trailer_accept", {63'd0, ok}, 64'd1);
    end
`endif
    wait_idle();
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] bq[$];
    wr_t        exp_q[$];
    int         d0;
    bit         ok;

    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h0A};
    vecs[0] = '{"basic", 2, -1, 0, 2, 32'h2008_0005, 32'h2409_000A, 1'b0, 1'b0, 1};
    vecs[1] = '{"stall", 2, 2, 3, 2, 32'h2008_0005, 32'h2409_000A, 1'b0, 1'b0, 1};
    vecs[2] = '{"one",   1, 1, 1, 1, 32'h2008_0005, 32'h0,        1'b0, 1'b0, 1};
    vecs[3] = '{"zero",  0, -1, 0, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1};
    vecs[4] = '{"over",  1025, -1, 0, 0, 32'h0,     32'h0,        1'b1, 1'b1, 0};

    bus.start = 1'b0; bus.load_len = '0; bus.byte_in = '0; bus.byte_valid = 1'b0;

    // Reset state
    rst = 1'b0;
    tick(2);
    check("rst_byte_ready", {63'd0, bus.byte_ready}, 64'd0);
    check("rst_im_we",      {63'd0, bus.im_we},      64'd0);
    check("rst_im_addr",    64'(bus.im_addr),        64'd0);
    check("rst_im_wdata",   64'(bus.im_wdata),       64'd0);
    check("rst_done",       {63'd0, bus.done},       64'd0);
    check("rst_err",        {63'd0, bus.err},        64'd0);
    check("rst_busy",       {63'd0, bus.busy},       64'd0);
    check("rst_cpu_rst",    {63'd0, bus.cpu_rst},    64'd1);
    rst = 1'b1;
    tick();

    // Directed vector table
    foreach (vecs[v]) begin
      bq.delete();
      if (vecs[v].len <= 2) for (int i = 0; i < 4 * vecs[v].len; i++) bq.push_back(prog[i]);
      wq.delete();
      d0 = done_cnt;
      run_load(vecs[v].len, bq, vecs[v].gap_at, vecs[v].gap_len);
      tick();
      check({vecs[v].name, "_nwr"}, 64'(wq.size()), 64'(vecs[v].exp_nwr));
      for (int i = 0; i < vecs[v].exp_nwr && i < wq.size(); i++) begin
        check({vecs[v].name, "_addr"}, 64'(wq[i].addr), 64'(i));
        check({vecs[v].name, "_data"}, 64'(wq[i].data), 64'(i == 0 ? vecs[v].w0 : vecs[v].w1));
      end
      check({vecs[v].name, "_err"},     {63'd0, bus.err},     64'(vecs[v].exp_err));
      check({vecs[v].name, "_cpu_rst"}, {63'd0, bus.cpu_rst}, 64'(vecs[v].exp_cpu_rst));
      check({vecs[v].name, "_done"},    64'(done_cnt - d0),   64'(vecs[v].exp_done));
`ifndef IM_LOADER_CHECKSUM_EN
      if (vecs[v].len == 0)
        check("zero_done_latency",
              {63'd0, (last_done_cyc - start_cyc >= 0) && (last_done_cyc - start_cyc <= 2)}, 64'd1);
`endif
    end

    // err stays sticky until the next accepted start clears it
    tick(3);
    check("err_sticky", {63'd0, bus.err}, 64'd1);
    do_start(0);
    check("err_cleared_by_start", {63'd0, bus.err}, 64'd0);
    bq.delete();
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(8'h00, ok);
    check("zero_trailer_accept", {63'd0, ok}, 64'd1);
`endif
    wait_idle();

    // One-cycle write latency, and a start pulse while busy is ignored
    wq.delete();
    d0 = done_cnt;
    do_start(1);
    check("load_cpu_rst", {63'd0, bus.cpu_rst}, 64'd1);
    check("load_busy",    {63'd0, bus.busy},    64'd1);
    send_byte(8'hDE, ok);
    send_byte(8'hAD, ok);
    bus.load_len = '0;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    send_byte(8'hBE, ok);
    send_byte(8'hEF, ok);
    check("lat_we",    {63'd0, bus.im_we},      64'd1);
    check("lat_addr",  64'(bus.im_addr),        64'd0);
    check("lat_data",  64'(bus.im_wdata),       64'hDEAD_BEEF);
    check("lat_ready", {63'd0, bus.byte_ready}, 64'd0);
    tick();
    check("lat_we_one_cycle", {63'd0, bus.im_we}, 64'd0);
`ifdef IM_LOADER_CHECKSUM_EN
    send_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, ok);
`endif
    wait_idle();
    tick();
    check("busy_start_nwr",  64'(wq.size()),      64'd1);
    check("busy_start_done", 64'(done_cnt - d0),  64'd1);
    check("post_done_cpu_rst", {63'd0, bus.cpu_rst}, 64'd0);

    // Reset in mid-load after six bytes of a two-word load
    wq.delete();
    d0 = done_cnt;
    do_start(2);
    for (int i = 0; i < 6; i++) send_byte(prog[i], ok);
    rst = 1'b0;
    tick();
    check("midrst_busy",    {63'd0, bus.busy},       64'd0);
    check("midrst_cpu_rst", {63'd0, bus.cpu_rst},    64'd1);
    check("midrst_ready",   {63'd0, bus.byte_ready}, 64'd0);
    rst = 1'b1;
    bus.byte_in = 8'h55; bus.byte_valid = 1'b1;
    tick(5);
    bus.byte_valid = 1'b0;
    check("midrst_nwr",  64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      check("midrst_addr", 64'(wq[0].addr), 64'd0);
      check("midrst_data", 64'(wq[0].data), 64'h2008_0005);
    end
    check("midrst_done",    64'(done_cnt - d0),   64'd0);
    check("midrst_cpu_rst2", {63'd0, bus.cpu_rst}, 64'd1);

`ifdef IM_LOADER_CHECKSUM_EN
    // Wrong checksum trailer
    wq.delete();
    d0 = done_cnt;
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(prog[i], ok);
    send_byte(8'h00, ok);
    check("badsum_accept", {63'd0, ok}, 64'd1);
    wait_idle();
    tick();
    check("badsum_err",     {63'd0, bus.err},     64'd1);
    check("badsum_cpu_rst", {63'd0, bus.cpu_rst}, 64'd1);
    check("badsum_done",    64'(done_cnt - d0),   64'd0);
    check("badsum_nwr",     64'(wq.size()),       64'd2);
`endif

    // Randomized loads against a word-level model
    for (int it = 0; it < 20; it++) begin
      int len;
      int npulse;
      len    = $urandom_range(1, 5);
      npulse = $urandom_range(0, 3);
      bq.delete();
      exp_q.delete();
      for (int i = 0; i < 4 * len; i++) bq.push_back(8'($urandom));
      for (int w = 0; w < len; w++)
        exp_q.push_back('{addr: ADDR_W'(w),
                          data: {bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]}});
      // Stray valid pulses while idle must not be taken
      for (int p = 0; p < npulse; p++) begin
        bus.byte_in = 8'($urandom); bus.byte_valid = 1'b1;
        tick();
        check("idle_not_ready", {63'd0, bus.byte_ready}, 64'd0);
      end
      bus.byte_valid = 1'b0;
      wq.delete();
      d0 = done_cnt;
      run_load(len, bq, $urandom_range(0, 4 * len - 1), $urandom_range(0, 3));
      tick();
      check("rnd_nwr", 64'(wq.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
        if (i < wq.size()) begin
          check("rnd_addr", 64'(wq[i].addr), 64'(exp_q[i].addr));
          check("rnd_data", 64'(wq[i].data), 64'(exp_q[i].data));
        end
      end
      check("rnd_done",    64'(done_cnt - d0),   64'd1);
      check("rnd_err",     {63'd0, bus.err},     64'd0);
      check("rnd_cpu_rst", {63'd0, bus.cpu_rst}, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, the instruction-memory word-address width (1024 words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a load request sampled in IDLE.
REQ-005 The block SHALL have port load_len, input, ADDR_W+1, the word count latched on an accepted start.
REQ-006 The block SHALL have port byte_in, input, 8, the program stream byte.
REQ-007 The block SHALL have port byte_valid, input, 1, meaning byte_in is valid.
REQ-008 The block SHALL have port byte_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-009 The block SHALL have port im_we, output, 1, the instruction-memory write strobe (one cycle per word).
REQ-010 The block SHALL have port im_addr, output, ADDR_W, the instruction-memory word address.
REQ-011 The block SHALL have port im_wdata, output, 32, the instruction word.
REQ-012 The block SHALL have port cpu_rst, output, 1, the active-high reset driven into the mips core.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle pulse on successful completion.
REQ-015 The block SHALL have port err, output, 1, a sticky error flag, cleared by an accepted start.

Function
REQ-016 The state machine SHALL have states IDLE, LOAD, WRITE, CHECK and DONE (CHECK is present only per REQ-031).
- IDLE: start=1 latches load_len, clears err and the word/byte counters, sets cpu_rst=1, and moves to LOAD.
- LOAD -> WRITE after the 4th accepted byte of a word.
- WRITE -> LOAD if words remain; otherwise -> CHECK or DONE.
- DONE -> IDLE after one cycle.
REQ-017 A byte SHALL transfer only in a cycle where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in LOAD (and in CHECK per REQ-031).
REQ-018 Bytes SHALL assemble big-endian: the first accepted byte goes to im_wdata[31:24] and the fourth to [7:0].
REQ-019 In the WRITE state, im_we SHALL be 1 for exactly one cycle, with im_addr equal to the word index (0, 1, 2, ...) and im_wdata equal to the assembled word; im_we SHALL be 0 in every other state.
REQ-020 Latency SHALL be one cycle: im_we is asserted in the cycle immediately following acceptance of the 4th byte.
REQ-021 The word index SHALL increment after each write and SHALL NOT wrap; the maximum legal load_len is 2^ADDR_W.
REQ-022 If load_len is 0, the block SHALL go from IDLE to DONE (or CHECK) with no writes.
REQ-023 If load_len exceeds 2^ADDR_W, the block SHALL set err=1, perform no writes, keep cpu_rst=1, and return to IDLE.
REQ-024 In DONE, the block SHALL pulse done=1 and SHALL drive cpu_rst=0 from the DONE cycle onward until the next accepted start or reset.
REQ-025 A start asserted while busy=1 SHALL be ignored.
REQ-026 Idle byte_valid pulses (in IDLE or DONE) SHALL be ignored and not consumed.

Reset
REQ-027 While rst=0 at a clock edge, the block SHALL enter IDLE and force the following values: byte_ready=0, im_we=0, im_addr=0, im_wdata=0, done=0, err=0, busy=0, cpu_rst=1.
REQ-028 A reset in mid-load SHALL discard any partial word, perform no further writes, and leave the CPU held in reset (cpu_rst=1).

Configuration
REQ-029 The macro IM_LOADER_CHECKSUM_EN SHALL select whether the checksum feature is compiled in.
REQ-030 Without IM_LOADER_CHECKSUM_EN, the CHECK state SHALL be absent and the last WRITE SHALL go directly to DONE.
REQ-031 With IM_LOADER_CHECKSUM_EN, the block SHALL keep a running XOR of all data bytes and then enter CHECK, which accepts one extra trailing byte.
- If the trailing byte equals the XOR: go to DONE.
- Otherwise: set err=1, keep cpu_rst=1, and return to IDLE with no done pulse.

Verification
REQ-032 The bench SHALL cover a basic load: reset, then start with load_len=2 and bytes 20 08 00 05 24 09 00 0A sent back-to-back -> im_we at addr 0 with data 0x20080005, then at addr 1 with 0x2409000A; done pulses; cpu_rst falls.
REQ-033 The bench SHALL cover a stalled stream: byte_valid low for 3 cycles between bytes 2 and 3 -> the same words are written with no extra im_we.
REQ-034 The bench SHALL cover a zero length: load_len=0 -> no im_we; done pulses within 2 cycles; err=0.
REQ-035 The bench SHALL cover an oversize length: load_len=1025 with ADDR_W=10 -> err=1, no writes, cpu_rst=1.
REQ-036 The bench SHALL cover reset mid-load: rst=0 after 6 bytes of a 2-word load -> only addr 0 is written; IDLE; cpu_rst=1; done never pulses.
REQ-037 With IM_LOADER_CHECKSUM_EN, the bench SHALL send the REQ-032 data plus trailer 0x0A -> done; with trailer 0x00 -> err=1 and cpu_rst=1.
